// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and encodings for the SRAM port arbiter.
package sram_port_arbiter_pkg;

    // Who currently owns the outstanding memory transaction.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    // One requester's view of a memory access, as driven onto mem_*.
    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int CNT_W    = 3;
    localparam int STREAK_W = 4;

endpackage

// File: rtl/sram_port_arbiter_arb_pick.sv
// Winner selection: data has priority unless fetch has waited out a full streak.
module sram_port_arbiter_arb_pick (
    input  logic accept,
    input  logic inst_req,
    input  logic data_req,
    input  logic streak_full,
    output logic gnt_inst,
    output logic gnt_data
);

    // Fetch wins when it is alone or when data has used up its streak allowance.
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (accept) begin
            if (inst_req && (streak_full || !data_req)) begin
                gnt_inst = 1'b1;
            end else if (data_req) begin
                gnt_data = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between the fetch and data requesters, one transaction in flight.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [3:0]  inst_wen,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [CNT_W-1:0]    LAT        = CNT_W'(RD_LAT);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    owner_e                owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  accept;
    logic                  streak_full;
    logic                  gnt_i;
    logic                  gnt_d;
    mem_req_t              sel;

    // A new access may start when idle or in the response cycle of the current one.
    // Reset blocks new grants so nothing leaks out while rst is high.
    assign accept      = !rst && ((owner_q == OWN_NONE) || (cnt_q == CNT_W'(1)));
    assign streak_full = (streak_q == STREAK_MAX);

    sram_port_arbiter_arb_pick u_arb_pick (
        .accept      (accept),
        .inst_req    (inst_req),
        .data_req    (data_req),
        .streak_full (streak_full),
        .gnt_inst    (gnt_i),
        .gnt_data    (gnt_d)
    );

    // State register: owner, latency counter, data-grant streak.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            cnt_q    <= '0;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            streak_q <= streak_d;
        end
    end

    // Next state: count down the outstanding access, reload on a fresh grant.
    always_comb begin
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
            owner_d = OWN_NONE;
        end
        if (gnt_i) begin
            owner_d  = OWN_INST;
            cnt_d    = LAT;
            streak_d = '0;
        end else if (gnt_d) begin
            owner_d = OWN_DATA;
            cnt_d   = LAT;
            if (!inst_req) begin
                streak_d = '0;
            end else if (!streak_full) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
    end

    // Outputs: grant handshakes, memory mux, response steering.
    always_comb begin
        sel = '0;
        if (gnt_i) begin
            sel = '{wen: inst_wen, addr: inst_addr, wdata: inst_wdata};
        end else if (gnt_d) begin
            sel = '{wen: data_wen, addr: data_addr, wdata: data_wdata};
        end
        inst_gnt    = gnt_i;
        data_gnt    = gnt_d;
        mem_en      = gnt_i | gnt_d;
        mem_wen     = sel.wen;
        mem_addr    = sel.addr;
        mem_wdata   = sel.wdata;
        inst_rvalid = !rst && (owner_q == OWN_INST) && (cnt_q == CNT_W'(1));
        data_rvalid = !rst && (owner_q == OWN_DATA) && (cnt_q == CNT_W'(1));
        inst_rdata  = inst_rvalid ? mem_rdata : '0;
        data_rdata  = data_rvalid ? mem_rdata : '0;
        busy        = !rst && (owner_q != OWN_NONE);
    end

endmodule
